pc_step_ctrl: RTL and testbench

Execution sequencer for the pipelined MIPS core: decides on which cycles the PC and pipeline registers advance by driving the shared `o_step` enable. It sits between the debug unit (command source) and the PC/pipeline, implementing run, single-step, pause, PC breakpoint and HALT-drain behaviour. It also keeps a retired-cycle counter for the debug unit to read.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/pc_step_ctrl_if.sv | 12 +
 rtl/drain_counter.sv | 34 +++
 rtl/pc_step_ctrl.sv | 135 +++++++++++++
 tb/tb_pc_step_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the execution sequencer: command codes, state encodings
// and default widths of the pipelined MIPS core.
package pipeline_pkg;

  localparam int unsigned NB           = 32;
  localparam int unsigned NB_CNT       = 32;
  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned CmdWidth     = 3;

  typedef enum logic [CmdWidth-1:0] {
    CmdNop    = 3'd0,
    CmdRun    = 3'd1,
    CmdStep   = 3'd2,
    CmdPause  = 3'd3,
    CmdClrCnt = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StStep  = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/pc_step_ctrl_if.sv
// Debug-unit command handshake into the execution sequencer.
interface pc_step_ctrl_if;
  import pipeline_pkg::*;

  logic                cmd_valid;
  logic [CmdWidth-1:0] cmd;
  logic                cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);

endinterface

// File: rtl/drain_counter.sv
// Counts the steps still owed to the pipeline after HALT has left IF.
module drain_counter #(
  parameter int unsigned Cycles = 4,
  localparam int unsigned Width = $clog2(Cycles + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = Width'(Cycles);
    end else if (dec_i && count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == Width'(1));

endmodule

// File: rtl/pc_step_ctrl.sv
// Execution sequencer: gates PC/pipeline advance for run, single-step, pause,
// PC breakpoint and HALT drain, and counts stepped cycles.
module pc_step_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned NB           = pipeline_pkg::NB,
  parameter int unsigned NB_CNT       = pipeline_pkg::NB_CNT,
  parameter int unsigned DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_reset,
  pc_step_ctrl_if.slave     cmd_bus,
  input  logic [NB-1:0]     i_pc,
  input  logic              i_halt_fetched,
  input  logic              i_bp_enable,
  input  logic [NB-1:0]     i_bp_addr,
  output logic              o_step,
  output logic [2:0]        o_state,
  output logic              o_bp_hit,
  output logic              o_done,
  output logic [NB_CNT-1:0] o_step_count
);

  state_e              state_q, state_d;
  logic                skip_bp_q, skip_bp_d;
  logic                bp_hit_q, bp_hit_d;
  logic [NB_CNT-1:0]   step_count_q, step_count_d;
  logic                cmd_fire;
  logic                bp_match;
  logic                step;
  logic                drain_load;
  logic                drain_dec;
  logic                drain_last;

  assign cmd_bus.cmd_ready = (state_q != StStep) && (state_q != StDrain);
  assign cmd_fire          = cmd_bus.cmd_valid && cmd_bus.cmd_ready;

  drain_counter #(
    .Cycles (DRAIN_CYCLES)
  ) u_drain_counter (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .load_i (drain_load),
    .dec_i  (drain_dec),
    .last_o (drain_last)
  );

  always_comb begin
    state_d    = state_q;
    skip_bp_d  = skip_bp_q;
    bp_hit_d   = 1'b0;
    bp_match   = 1'b0;
    step       = 1'b0;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire && cmd_bus.cmd == CmdRun) begin
          state_d   = StRun;
          // Resuming at the breakpoint address must step over it once.
          skip_bp_d = 1'b1;
        end else if (cmd_fire && cmd_bus.cmd == CmdStep) begin
          state_d = StStep;
        end
      end
      StRun: begin
        bp_match  = i_bp_enable && (i_pc == i_bp_addr) && !skip_bp_q;
        step      = !bp_match;
        skip_bp_d = 1'b0;
        if (bp_match) begin
          state_d  = StIdle;
          bp_hit_d = 1'b1;
        end else if (i_halt_fetched) begin
          state_d    = StDrain;
          drain_load = 1'b1;
        end else if (cmd_fire && cmd_bus.cmd == CmdPause) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        step = 1'b1;
        if (i_halt_fetched) begin
          state_d    = StDrain;
          drain_load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        step      = 1'b1;
        drain_dec = 1'b1;
        if (drain_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clear wins over a concurrent increment; the counter sticks at all-ones.
  always_comb begin
    step_count_d = step_count_q;
    if (cmd_fire && cmd_bus.cmd == CmdClrCnt) begin
      step_count_d = '0;
    end else if (step && step_count_q != '1) begin
      step_count_d = step_count_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      skip_bp_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      skip_bp_q    <= skip_bp_d;
      bp_hit_q     <= bp_hit_d;
      step_count_q <= step_count_d;
    end
  end

  assign o_step       = step;
  assign o_state      = state_q;
  assign o_bp_hit     = bp_hit_q;
  assign o_done       = (state_q == StDone);
  assign o_step_count = step_count_q;

endmodule

// File: tb/tb_pc_step_ctrl.sv
// Directed self-checking bench for pc_step_ctrl with a simple PC plant (+4 per step).
module tb_pc_step_ctrl;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        halt_fetched;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic        step;
  logic [2:0]  state;
  logic        bp_hit;
  logic        done;
  logic [31:0] step_count;

  int checks;
  int errors;

  pc_step_ctrl_if cmd_bus ();

  pc_step_ctrl #(
    .NB           (32),
    .NB_CNT       (32),
    .DRAIN_CYCLES (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .cmd_bus        (cmd_bus.slave),
    .i_pc           (pc),
    .i_halt_fetched (halt_fetched),
    .i_bp_enable    (bp_enable),
    .i_bp_addr      (bp_addr),
    .o_step         (step),
    .o_state        (state),
    .o_bp_hit       (bp_hit),
    .o_done         (done),
    .o_step_count   (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register of the core: advances by one instruction on every stepped edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'h0;
    else if (step) pc <= pc + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command for exactly one edge.
  task automatic issue(input logic [2:0] c);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd       = c;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd       = 3'd0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd       = 3'd0;
    halt_fetched      = 1'b0;
    bp_enable         = 1'b0;
    bp_addr           = 32'h0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_step", 32'(step), 32'd0);
    check_eq("rst_count", step_count, 32'd0);
    check_eq("rst_bp_hit", 32'(bp_hit), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("idle_pc", pc, 32'h0);
    check_eq("idle_step", 32'(step), 32'd0);
    check_eq("idle_ready", 32'(cmd_bus.cmd_ready), 32'd1);

    // Three single steps.
    for (int i = 1; i <= 3; i++) begin
      issue(CmdStep);
      check_eq("step_state", 32'(state), 32'd2);
      check_eq("step_on", 32'(step), 32'd1);
      check_eq("step_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      tick();
      check_eq("step_pc", pc, 32'(4 * i));
      check_eq("step_back_idle", 32'(state), 32'd0);
      check_eq("step_off", 32'(step), 32'd0);
      check_eq("step_ready_back", 32'(cmd_bus.cmd_ready), 32'd1);
    end
    check_eq("step_count3", step_count, 32'd3);

    // Breakpoint at 0x10 from PC 0xC.
    bp_enable = 1'b1;
    bp_addr   = 32'h10;
    issue(CmdRun);
    check_eq("run_state", 32'(state), 32'd1);
    check_eq("run_step", 32'(step), 32'd1);
    tick();
    check_eq("bp_pc", pc, 32'h10);
    check_eq("bp_no_step", 32'(step), 32'd0);
    tick();
    check_eq("bp_idle", 32'(state), 32'd0);
    check_eq("bp_hit_pulse", 32'(bp_hit), 32'd1);
    check_eq("bp_pc_hold", pc, 32'h10);
    tick();
    check_eq("bp_hit_clear", 32'(bp_hit), 32'd0);
    check_eq("bp_count", step_count, 32'd4);

    // Resume over the breakpoint, then pause.
    issue(CmdRun);
    check_eq("resume_step", 32'(step), 32'd1);
    tick();
    check_eq("resume_pc", pc, 32'h14);
    check_eq("resume_no_hit", 32'(bp_hit), 32'd0);
    check_eq("resume_running", 32'(state), 32'd1);
    issue(CmdPause);
    check_eq("pause_pc", pc, 32'h18);
    check_eq("pause_idle", 32'(state), 32'd0);
    check_eq("pause_count", step_count, 32'd6);
    tick();
    check_eq("pause_hold_pc", pc, 32'h18);

    // HALT fetched at PC 0x20 -> 1 + 4 steps, then DONE.
    bp_enable = 1'b0;
    issue(CmdRun);
    tick();
    tick();
    check_eq("halt_pc", pc, 32'h20);
    halt_fetched = 1'b1;
    tick();
    halt_fetched = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_state", 32'(state), 32'd3);
      check_eq("drain_step", 32'(step), 32'd1);
      check_eq("drain_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      tick();
    end
    check_eq("done_state", 32'(state), 32'd4);
    check_eq("done_level", 32'(done), 32'd1);
    check_eq("done_step", 32'(step), 32'd0);
    check_eq("done_pc", pc, 32'h34);
    check_eq("done_count", step_count, 32'd13);
    issue(CmdRun);
    check_eq("done_run_drop", 32'(state), 32'd4);
    issue(CmdStep);
    check_eq("done_step_drop", 32'(state), 32'd4);
    check_eq("done_pc_hold", pc, 32'h34);
    issue(CmdClrCnt);
    check_eq("done_clr", step_count, 32'd0);

    // PAUSE together with HALT -> drain wins; reset in drain cycle 2.
    rst_n = 1'b0;
    #1;
    check_eq("rst2_state", 32'(state), 32'd0);
    check_eq("rst2_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(CmdRun);
    halt_fetched = 1'b1;
    issue(CmdPause);
    halt_fetched = 1'b0;
    check_eq("pause_halt_drain", 32'(state), 32'd3);
    check_eq("pause_halt_pc", pc, 32'h4);
    tick();
    check_eq("drain2_state", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_step", 32'(step), 32'd0);
    check_eq("abort_count", step_count, 32'd0);
    check_eq("abort_pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("abort_idle", 32'(state), 32'd0);
    check_eq("abort_no_step", 32'(step), 32'd0);

    // CLR_CNT on a stepping cycle -> count 0.
    issue(CmdRun);
    tick();
    tick();
    check_eq("pre_clr_count", step_count, 32'd2);
    issue(CmdClrCnt);
    check_eq("clr_with_step", step_count, 32'd0);
    check_eq("clr_still_run", 32'(state), 32'd1);
    tick();
    check_eq("post_clr_count", step_count, 32'd1);
    issue(CmdPause);
    check_eq("final_idle", 32'(state), 32'd0);
    check_eq("final_count", step_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
